// File: rtl/pipe_in_deserializer_if.sv
// Host-word input and PipeIn message output bundle of the deserializer.
// The slave modport is the deserializer; the master modport is the host/downstream side.
interface pipe_in_deserializer_if;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         enq__ENA;
    logic [143:0] enq_v;
    logic         enq__RDY;
    logic [15:0]  msg_count;
    logic [7:0]   drop_count;

    modport master (
        output in_valid, in_data, enq__RDY,
        input  in_ready, enq__ENA, enq_v, msg_count, drop_count
    );

    modport slave (
        input  in_valid, in_data, enq__RDY,
        output in_ready, enq__ENA, enq_v, msg_count, drop_count
    );
endinterface

// File: rtl/pipe_in_deserializer.sv
// Assembles a header word plus up to four 32-bit payload words into one 144-bit
// PipeIn message; oversize messages are swallowed and counted.
module pipe_in_deserializer (
    input  logic                   CLK,
    input  logic                   RST,
    pipe_in_deserializer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_DROP,
        S_HOLD
    } state_t;

    state_t       r_state, w_state_next;
    logic [15:0]  r_remaining, w_remaining_next;
    logic [1:0]   r_word_idx, w_word_idx_next;
    logic [143:0] r_msg, w_msg_next;
    logic [15:0]  r_msg_count, w_msg_count_next;
    logic [7:0]   r_drop_count, w_drop_count_next;

    logic         w_ready;
    logic         w_accept;
    logic         w_ena;
    logic [15:0]  w_hdr_len;
    logic [15:0]  w_hdr_id;
    logic [127:0] w_payload_upd;

    assign w_ready   = (r_state != S_HOLD);
    assign w_accept  = bus.in_valid && w_ready;
    assign w_ena     = (r_state == S_HOLD) && bus.enq__RDY;
    assign w_hdr_len = bus.in_data[31:16];
    assign w_hdr_id  = bus.in_data[15:0];

    // Payload image with the incoming word dropped into the lane it belongs to.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_payload_upd[32*gi +: 32] =
                (r_word_idx == 2'(gi)) ? bus.in_data : r_msg[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        w_state_next      = r_state;
        w_remaining_next  = r_remaining;
        w_word_idx_next   = r_word_idx;
        w_msg_next        = r_msg;
        w_msg_count_next  = r_msg_count;
        w_drop_count_next = r_drop_count;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_msg_next       = {w_hdr_id, 128'd0};
                    w_remaining_next = w_hdr_len;
                    w_word_idx_next  = 2'd0;
                    if (w_hdr_len == 16'd0) begin
                        w_state_next = S_HOLD;
                    end else if (w_hdr_len <= 16'd4) begin
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_state_next = S_DROP;
                        if (r_drop_count != 8'hFF) begin
                            w_drop_count_next = r_drop_count + 8'd1;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    w_msg_next[127:0] = w_payload_upd;
                    w_word_idx_next   = r_word_idx + 2'd1;
                    w_remaining_next  = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (w_accept) begin
                    w_remaining_next = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (w_ena) begin
                    w_state_next     = S_IDLE;
                    w_msg_count_next = r_msg_count + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_remaining  <= 16'd0;
            r_word_idx   <= 2'd0;
            r_msg        <= 144'd0;
            r_msg_count  <= 16'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_remaining  <= w_remaining_next;
            r_word_idx   <= w_word_idx_next;
            r_msg        <= w_msg_next;
            r_msg_count  <= w_msg_count_next;
            r_drop_count <= w_drop_count_next;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.enq__ENA   = w_ena;
    assign bus.enq_v      = r_msg;
    assign bus.msg_count  = r_msg_count;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_pipe_in_deserializer.sv
// Directed-vector bench for pipe_in_deserializer: a table of per-cycle expectations
// followed by hand-written stall, saturation, long-drop and reset sequences.
module tb_pipe_in_deserializer;
    logic clk;
    logic rst;

    pipe_in_deserializer_if bus ();

    pipe_in_deserializer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         rdy;
        logic         e_ready;
        logic         e_ena;
        logic [143:0] e_v;
        logic [15:0]  e_mc;
        logic [7:0]   e_dc;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic v, input logic [31:0] d, input logic rdy,
                       input logic e_ready, input logic e_ena, input logic [143:0] e_v,
                       input logic [15:0] e_mc, input logic [7:0] e_dc);
        vec_t t;
        t.v = v; t.d = d; t.rdy = rdy;
        t.e_ready = e_ready; t.e_ena = e_ena; t.e_v = e_v;
        t.e_mc = e_mc; t.e_dc = e_dc;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are then sampled 1ns later.
    task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.enq__RDY = rdy;
        #1;
    endtask

    localparam logic [143:0] V1A = {16'h00AB, 128'h0};
    localparam logic [143:0] V1B = {16'h00AB, 96'h0, 32'h11111111};
    localparam logic [143:0] V1  = {16'h00AB, 64'h0, 32'h22222222, 32'h11111111};
    localparam logic [143:0] V2  = {16'h0005, 128'h0};
    localparam logic [143:0] V3  = {16'h0001, 128'h0};
    localparam logic [143:0] V4H = {16'h0002, 128'h0};
    localparam logic [143:0] V4  = {16'h0002, 96'h0, 32'hDEADBEEF};
    localparam logic [143:0] V5H = {16'h0007, 128'h0};
    localparam logic [143:0] V5  = {16'h0007, 96'h0, 32'hCAFEF00D};
    localparam logic [143:0] V6  = {16'h0009, 32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001};

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.enq__RDY = 1'b0;
        rst = 1'b1;

        #2;
        chk("rst_ready", 144'(bus.in_ready), 144'd1);
        chk("rst_ena",   144'(bus.enq__ENA), 144'd0);
        chk("rst_enqv",  bus.enq_v, 144'd0);
        chk("rst_mc",    144'(bus.msg_count), 144'd0);
        chk("rst_dc",    144'(bus.drop_count), 144'd0);
        $display("reset state checked");
        #10 rst = 1'b0;

        // two-word message, then N=0
        add(1, 32'h000200AB, 1,  1, 0, 144'd0, 16'd0, 8'd0);
        add(1, 32'h11111111, 1,  1, 0, V1A,    16'd0, 8'd0);
        add(1, 32'h22222222, 1,  1, 0, V1B,    16'd0, 8'd0);
        add(0, 32'h0,        1,  0, 1, V1,     16'd0, 8'd0);
        add(1, 32'h00000005, 1,  1, 0, V1,     16'd1, 8'd0);
        add(0, 32'h0,        1,  0, 1, V2,     16'd1, 8'd0);
        // oversize drop followed by a one-word message
        add(1, 32'h00060001, 1,  1, 0, V2,     16'd2, 8'd0);
        for (int k = 0; k < 6; k++)
            add(1, 32'h50000000 + 32'(k), 1,  1, 0, V3, 16'd2, 8'd1);
        add(1, 32'h00010002, 1,  1, 0, V3,     16'd2, 8'd1);
        add(1, 32'hDEADBEEF, 1,  1, 0, V4H,    16'd2, 8'd1);
        add(0, 32'h0,        1,  0, 1, V4,     16'd2, 8'd1);
        add(0, 32'h0,        1,  1, 0, V4,     16'd3, 8'd1);
        // idle gap inside PAYLOAD
        add(1, 32'h00010007, 1,  1, 0, V4,     16'd3, 8'd1);
        add(0, 32'h12345678, 1,  1, 0, V5H,    16'd3, 8'd1);
        add(1, 32'hCAFEF00D, 1,  1, 0, V5H,    16'd3, 8'd1);
        add(0, 32'h0,        1,  0, 1, V5,     16'd3, 8'd1);
        add(0, 32'h0,        0,  1, 0, V5,     16'd4, 8'd1);

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].d, vq[i].rdy);
            $display("vec %0d: valid=%0b data=%h rdy=%0b -> ready=%0b ena=%0b mc=%0d dc=%0d",
                     i, vq[i].v, vq[i].d, vq[i].rdy, bus.in_ready, bus.enq__ENA,
                     bus.msg_count, bus.drop_count);
            chk($sformatf("v%0d_ready", i), 144'(bus.in_ready),   144'(vq[i].e_ready));
            chk($sformatf("v%0d_ena",   i), 144'(bus.enq__ENA),   144'(vq[i].e_ena));
            chk($sformatf("v%0d_enqv",  i), bus.enq_v,            vq[i].e_v);
            chk($sformatf("v%0d_mc",    i), 144'(bus.msg_count),  144'(vq[i].e_mc));
            chk($sformatf("v%0d_dc",    i), 144'(bus.drop_count), 144'(vq[i].e_dc));
        end

        // four-word message held for 10 cycles with downstream not ready
        drive(1, 32'h00040009, 0);
        for (int k = 1; k <= 4; k++) drive(1, 32'hA0000000 + 32'(k), 0);
        for (int k = 0; k < 10; k++) begin
            drive(k[0], 32'h0BAD0000 + 32'(k), 0);
            chk("hold_ready", 144'(bus.in_ready), 144'd0);
            chk("hold_ena",   144'(bus.enq__ENA), 144'd0);
            chk("hold_enqv",  bus.enq_v, V6);
        end
        drive(0, 32'h0, 1);
        chk("hold_release_ena", 144'(bus.enq__ENA), 144'd1);
        chk("hold_release_v",   bus.enq_v, V6);
        drive(0, 32'h0, 1);
        chk("hold_after_ready", 144'(bus.in_ready), 144'd1);
        chk("hold_after_mc",    144'(bus.msg_count), 144'd5);
        $display("hold sequence: 10 stalled cycles, released, mc=%0d", bus.msg_count);

        // 256 oversize messages saturate drop_count
        for (int i = 0; i < 256; i++) begin
            drive(1, 32'h00050000 | 32'(i), 1);
            for (int j = 0; j < 5; j++) drive(1, 32'(j), 1);
            if (i == 0) begin
                drive(0, 32'h0, 1);
                chk("drop_first_dc", 144'(bus.drop_count), 144'd2);
            end
        end
        drive(0, 32'h0, 1);
        chk("drop_sat_dc",  144'(bus.drop_count), 144'd255);
        chk("drop_sat_mc",  144'(bus.msg_count), 144'd5);
        chk("drop_sat_ena", 144'(bus.enq__ENA), 144'd0);
        $display("drop saturation: dc=%0d", bus.drop_count);

        // N=0xFFFF consumes exactly 65535 words
        drive(1, 32'hFFFF0010, 1);
        for (int k = 0; k < 65534; k++) drive(1, 32'h00000000, 1);
        drive(1, 32'h00000022, 1);
        drive(0, 32'h0, 1);
        chk("long_drop_no_ena", 144'(bus.enq__ENA), 144'd0);
        chk("long_drop_ready",  144'(bus.in_ready), 144'd1);
        drive(1, 32'h00000033, 1);
        drive(0, 32'h0, 1);
        chk("long_drop_next_ena", 144'(bus.enq__ENA), 144'd1);
        chk("long_drop_next_v",   bus.enq_v, {16'h0033, 128'h0});
        chk("long_drop_dc",       144'(bus.drop_count), 144'd255);
        $display("long drop: 65535 words consumed, following N=0 header delivered");

        // reset while a message is held
        drive(1, 32'h00000044, 0);
        drive(0, 32'h0, 0);
        chk("rhold_ready", 144'(bus.in_ready), 144'd0);
        bus.enq__RDY = 1'b1;
        rst = 1'b1;
        #1;
        chk("rhold_ena",   144'(bus.enq__ENA), 144'd0);
        chk("rhold_enqv",  bus.enq_v, 144'd0);
        chk("rhold_mc",    144'(bus.msg_count), 144'd0);
        chk("rhold_dc",    144'(bus.drop_count), 144'd0);
        #1 rst = 1'b0;
        drive(0, 32'h0, 1);
        chk("rhold_after_ena", 144'(bus.enq__ENA), 144'd0);
        $display("reset during HOLD discarded the message");

        // reset after 2 of 4 payload words
        drive(1, 32'h00040001, 1);
        drive(1, 32'h11110000, 1);
        drive(1, 32'h22220000, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rpay_ready", 144'(bus.in_ready), 144'd1);
        chk("rpay_enqv",  bus.enq_v, 144'd0);
        #1 rst = 1'b0;
        drive(1, 32'h00010003, 1);
        chk("rpay_hdr_ena", 144'(bus.enq__ENA), 144'd0);
        drive(1, 32'h00000005, 1);
        drive(0, 32'h0, 1);
        chk("rpay_ena",  144'(bus.enq__ENA), 144'd1);
        chk("rpay_enqv", bus.enq_v, {16'h0003, 96'h0, 32'h00000005});
        drive(0, 32'h0, 1);
        chk("rpay_mc",   144'(bus.msg_count), 144'd1);
        $display("reset mid-payload: next message method=%h mc=%0d",
                 bus.enq_v[143:128], bus.msg_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
